sensor_fault_monitor: RTL and testbench
=======================================

SENSOR_FAULT_MONITOR -- requirements
Module: sensor_fault_monitor

Interface
REQ-001 Parameter NUM_SENSORS, default 7: number of sensor inputs, legal range 2..32.
REQ-002 Parameter THRESH, default 2: minimum count of failed (low) sensors that forms a fault condition, legal range 1..NUM_SENSORS.
REQ-003 Parameter PERSIST, default 4: consecutive cycles the fault condition must hold before the alarm is raised, legal range 1..255.
REQ-004 Port Clock, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port Resetn, input, 1: asynchronous, active-low reset.
REQ-006 Port X, input, NUM_SENSORS: sensor status; 1 = healthy, 0 = failed.
REQ-007 Port clr, input, 1: alarm acknowledge/clear request.
REQ-008 Port f, output, 1: registered alarm flag.
REQ-009 Port pending, output, 1: registered; fault condition present but not yet persistent.
REQ-010 Port fail_cnt, output, clog2(NUM_SENSORS+1): registered count of failed sensors.
REQ-011 Port alarm_events, output, 8: saturating count of alarm entries.

Function
REQ-012 fail_cnt SHALL equal the number of zero bits of X sampled at the previous rising edge (1-cycle latency).
REQ-013 cond SHALL be defined as fail_cnt >= THRESH, evaluated on the registered fail_cnt.
REQ-014 The FSM SHALL have exactly three states: S_OK, S_PEND, S_ALARM.
REQ-015 S_OK: if cond and PERSIST==1, go to S_ALARM; if cond and PERSIST>1, go to S_PEND with the persistence counter set to 1; otherwise stay.
REQ-016 S_PEND: if !cond, go to S_OK and clear the counter; if cond and counter==PERSIST-1, go to S_ALARM; otherwise increment the counter.
REQ-017 S_ALARM: if clr and !cond, go to S_OK; clr while cond SHALL be ignored; otherwise stay (alarm latched).
REQ-018 f SHALL be 1 exactly when state==S_ALARM; pending SHALL be 1 exactly when state==S_PEND.
REQ-019 Worst-case latency from X meeting THRESH to f=1 SHALL be PERSIST+1 cycles.
REQ-020 alarm_events SHALL increment by 1 on every transition into S_ALARM and saturate at 255.
REQ-021 A cond dropout of a single cycle in S_PEND SHALL restart persistence from S_OK.

Reset
REQ-022 When Resetn=0: state=S_OK, persistence counter=0, fail_cnt=0, f=0, pending=0, alarm_events=0, applied immediately and independent of Clock.
REQ-023 Reset asserted in any state, including S_ALARM, SHALL discard the latched alarm; the first post-reset evaluation uses freshly sampled X.

Configuration
REQ-024 Macro SENSOR_MASK_EN: when defined, an extra input mask[NUM_SENSORS-1:0] SHALL be present; sensors with mask bit 1 SHALL be treated as healthy regardless of X.
REQ-025 Without SENSOR_MASK_EN, the mask port SHALL be absent and all sensors SHALL be counted.

Structure
REQ-026 A shared package sensor_mon_pkg SHALL hold the state enumeration (S_OK, S_PEND, S_ALARM) and the alarm_events width constant (8).
REQ-027 The failed-sensor count SHALL be implemented in one sub-module, sensor_popcount, parametrised by NUM_SENSORS and purely combinational.
REQ-028 The FSM, counters and output registers SHALL reside in sensor_fault_monitor.

Verification
REQ-029 Defaults, X=7'b1111111 then X=7'b1111100 held -> fail_cnt=2 after 1 cycle, pending=1 after 2 cycles, f=1 after 5 cycles, alarm_events=1.
REQ-030 Defaults, X=7'b1111110 held 20 cycles -> fail_cnt=1, f=0 and pending=0 throughout.
REQ-031 Defaults, 2 failures held 3 cycles, then 1 cycle healthy, then 2 failures again -> f stays 0 for the first 7 cycles; f=1 only 5 cycles after the second onset.
REQ-032 In S_ALARM, clr=1 with X=7'b1111100 -> f stays 1; restore X=7'b1111111, then clr=1 -> f=0 on the cycle after cond drops.
REQ-033 PERSIST=1, THRESH=3, NUM_SENSORS=16, X=16'hFFF8 -> f=1 two cycles after X is applied; 300 alarm/clear cycles -> alarm_events=255.
REQ-034 With SENSOR_MASK_EN, mask=7'b0000011 and X=7'b1111100 -> fail_cnt=0, f=0; Resetn pulsed low in S_ALARM -> f=0 immediately and alarm_events=0.

Source files
------------

// File: rtl/sensor_mon_pkg.sv
// Shared definitions for the sensor fault monitor: FSM state encoding and
// the widths of the alarm event counter and persistence counter.
package sensor_mon_pkg;

  // Width of the saturating alarm_events counter.
  localparam int EVENT_W = 8;

  // Width of the persistence counter; PERSIST is at most 255.
  localparam int PERSIST_W = 8;

  // Monitor states: healthy, fault seen but not yet persistent, alarm latched.
  typedef enum logic [1:0] {
    S_OK    = 2'd0,
    S_PEND  = 2'd1,
    S_ALARM = 2'd2
  } state_t;

endpackage

// File: rtl/sensor_popcount.sv
// Purely combinational population count of the failed-sensor vector.
// A 1 in 'failed' marks one failed sensor; 'count' is how many are set.
module sensor_popcount #(
  parameter int NUM_SENSORS = 7
) (
  input  logic [NUM_SENSORS-1:0]         failed,
  output logic [$clog2(NUM_SENSORS+1)-1:0] count
);

  localparam int CNT_W = $clog2(NUM_SENSORS + 1);

  // Add up the failed bits one at a time; synthesis builds an adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      count = count + CNT_W'(failed[i]);
    end
  end

endmodule

// File: rtl/sensor_fault_monitor.sv
// Sensor fault monitor: counts failed (low) sensors every cycle and raises a
// latched alarm once THRESH or more have failed for PERSIST consecutive
// cycles. The alarm is cleared only by clr while the fault is gone.
// Optional build macro SENSOR_MASK_EN adds a 'mask' input; a sensor whose
// mask bit is 1 is always treated as healthy.
//
// Handshake note: there is no valid/ready traffic here. X and clr are plain
// level inputs sampled on every rising Clock edge; every output is a
// registered level that is meaningful on every cycle after reset.
module sensor_fault_monitor
  import sensor_mon_pkg::*;
#(
  parameter int NUM_SENSORS = 7,
  parameter int THRESH      = 2,
  parameter int PERSIST     = 4
) (
  input  logic                             Clock,
  input  logic                             Resetn,
  input  logic [NUM_SENSORS-1:0]           X,
`ifdef SENSOR_MASK_EN
  input  logic [NUM_SENSORS-1:0]           mask,
`endif
  input  logic                             clr,
  output logic                             f,
  output logic                             pending,
  output logic [$clog2(NUM_SENSORS+1)-1:0] fail_cnt,
  output logic [EVENT_W-1:0]               alarm_events,
  output state_t                           state_dbg
);

  localparam int CNT_W = $clog2(NUM_SENSORS + 1);
  localparam logic [CNT_W-1:0]     THRESH_C    = CNT_W'(THRESH);
  localparam logic [PERSIST_W-1:0] PERSIST_TOP = PERSIST_W'(PERSIST - 1);
  localparam logic [EVENT_W-1:0]   EVENT_MAX   = '1;

  logic [NUM_SENSORS-1:0] failed_vec;
  logic [CNT_W-1:0]       fail_cnt_nxt;
  logic                   cond;
  logic                   alarm_enter;

  state_t                 state;
  state_t                 state_nxt;
  logic [PERSIST_W-1:0]   pcnt;
  logic [PERSIST_W-1:0]   pcnt_nxt;

  // A sensor counts as failed when it reads 0 and is not masked off.
`ifdef SENSOR_MASK_EN
  assign failed_vec = ~X & ~mask;
`else
  assign failed_vec = ~X;
`endif

  sensor_popcount #(
    .NUM_SENSORS(NUM_SENSORS)
  ) u_popcount (
    .failed(failed_vec),
    .count (fail_cnt_nxt)
  );

  // Register the failed-sensor count; this is the 1-cycle sampling stage.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      fail_cnt <= '0;
    end else begin
      fail_cnt <= fail_cnt_nxt;
    end
  end

  // Fault condition is judged on the registered count, never on raw X.
  assign cond = (fail_cnt >= THRESH_C);

  // Next-state and persistence-counter logic for the three-state FSM.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    case (state)
      S_OK: begin
        pcnt_nxt = '0;
        if (cond) begin
          if (PERSIST == 1) begin
            state_nxt = S_ALARM;
          end else begin
            state_nxt = S_PEND;
            pcnt_nxt  = PERSIST_W'(1);
          end
        end
      end
      S_PEND: begin
        if (!cond) begin
          // Any dropout restarts persistence from scratch.
          state_nxt = S_OK;
          pcnt_nxt  = '0;
        end else if (pcnt == PERSIST_TOP) begin
          state_nxt = S_ALARM;
          pcnt_nxt  = '0;
        end else begin
          pcnt_nxt = pcnt + PERSIST_W'(1);
        end
      end
      S_ALARM: begin
        pcnt_nxt = '0;
        // Acknowledge only takes effect once the fault has gone away.
        if (clr && !cond) begin
          state_nxt = S_OK;
        end
      end
      default: begin
        state_nxt = S_OK;
        pcnt_nxt  = '0;
      end
    endcase
  end

  assign alarm_enter = (state != S_ALARM) && (state_nxt == S_ALARM);

  // State, persistence counter and registered flag outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_OK;
      pcnt    <= '0;
      f       <= 1'b0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pcnt    <= pcnt_nxt;
      f       <= (state_nxt == S_ALARM);
      pending <= (state_nxt == S_PEND);
    end
  end

  // Saturating count of entries into the alarm state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      alarm_events <= '0;
    end else if (alarm_enter && (alarm_events != EVENT_MAX)) begin
      alarm_events <= alarm_events + EVENT_W'(1);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sensor_fault_monitor.sv
// Bench for sensor_fault_monitor: a default-parameter instance checked every
// cycle against a run-length model, plus a PERSIST=1/THRESH=3/16-sensor
// instance checked with hand-computed values.
module tb_sensor_fault_monitor;
  import sensor_mon_pkg::*;

  localparam int THRESH_A  = 2;
  localparam int PERSIST_A = 4;

  // ---------------- clock / reset ----------------
  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- DUT A: defaults ----------------
  logic [6:0] x_a    = 7'h7F;
  logic [6:0] mask_a = 7'h00;
  logic       clr_a  = 1'b0;
  logic       f_a;
  logic       pend_a;
  logic [2:0] fc_a;
  logic [7:0] ev_a;
  state_t     st_a;

  sensor_fault_monitor dut_a (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .X           (x_a),
`ifdef SENSOR_MASK_EN
    .mask        (mask_a),
`endif
    .clr         (clr_a),
    .f           (f_a),
    .pending     (pend_a),
    .fail_cnt    (fc_a),
    .alarm_events(ev_a),
    .state_dbg   (st_a)
  );

  // ---------------- DUT B: PERSIST=1, THRESH=3, 16 sensors ----------------
  logic [15:0] x_b    = 16'hFFFF;
  logic [15:0] mask_b = 16'h0000;
  logic        clr_b  = 1'b0;
  logic        f_b;
  logic        pend_b;
  logic [4:0]  fc_b;
  logic [7:0]  ev_b;
  state_t      st_b;

  sensor_fault_monitor #(
    .NUM_SENSORS(16),
    .THRESH     (3),
    .PERSIST    (1)
  ) dut_b (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .X           (x_b),
`ifdef SENSOR_MASK_EN
    .mask        (mask_b),
`endif
    .clr         (clr_b),
    .f           (f_b),
    .pending     (pend_b),
    .fail_cnt    (fc_b),
    .alarm_events(ev_b),
    .state_dbg   (st_b)
  );

  // ---------------- scoreboard counters ----------------
  int checks_total  = 0;
  int checks_passed = 0;
  bit model_on      = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // ---------------- behavioural model of DUT A ----------------
  // Model view: fail count is the number of zeros seen last edge; the alarm
  // latches once the condition has held for PERSIST consecutive edges.
  int m_fail   = 0;
  int m_run    = 0;
  int m_events = 0;
  bit m_alarm  = 1'b0;
  logic [6:0] eff_a;
  bit m_cond;

`ifdef SENSOR_MASK_EN
  assign eff_a = x_a | mask_a;
`else
  assign eff_a = x_a;
`endif
  assign m_cond = (m_fail >= THRESH_A);

  function automatic int zeros7(input logic [6:0] v);
    int n = 0;
    for (int i = 0; i < 7; i++) if (!v[i]) n++;
    return n;
  endfunction

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_fail   <= 0;
      m_run    <= 0;
      m_events <= 0;
      m_alarm  <= 1'b0;
    end else begin
      m_fail <= zeros7(eff_a);
      if (m_alarm) begin
        if (clr_a && !m_cond) m_alarm <= 1'b0;
      end else if (m_cond && (m_run + 1 >= PERSIST_A)) begin
        m_alarm  <= 1'b1;
        m_run    <= 0;
        m_events <= (m_events < 255) ? m_events + 1 : 255;
      end else begin
        m_run <= m_cond ? m_run + 1 : 0;
      end
    end
  end

  // Per-cycle comparison of DUT A against the model.
  always @(negedge Clock) begin
    if (Resetn && model_on) begin
      check("model_fail_cnt", int'(fc_a), m_fail);
      check("model_f", int'(f_a), int'(m_alarm));
      check("model_pending", int'(pend_a), int'(!m_alarm && m_run > 0));
      check("model_events", int'(ev_a), m_events);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] vec_tab [12] = '{8'h7C, 8'h7C, 8'hFC, 8'h00, 8'hFF, 8'hFF,
                               8'h5D, 8'h7B, 8'h2A, 8'h2A, 8'hFE, 8'h7F};

  initial begin
    // Reset state
    step(2);
    check("rst_f_a", int'(f_a), 0);
    check("rst_pending_a", int'(pend_a), 0);
    check("rst_fail_cnt_a", int'(fc_a), 0);
    check("rst_events_a", int'(ev_a), 0);
    check("rst_state_a", int'(st_a), int'(S_OK));
    check("rst_f_b", int'(f_b), 0);
    Resetn   = 1'b1;
    model_on = 1'b1;

    // Two failures held: count, pending, then alarm five cycles after onset
    x_a = 7'b1111111;
    step(2);
    x_a = 7'b1111100;
    step(1);
    check("onset_fail_cnt", int'(fc_a), 2);
    check("onset_pending_c1", int'(pend_a), 0);
    step(1);
    check("onset_pending_c2", int'(pend_a), 1);
    step(2);
    check("onset_f_c4", int'(f_a), 0);
    step(1);
    check("onset_f_c5", int'(f_a), 1);
    check("onset_events", int'(ev_a), 1);

    // clr ignored while the fault persists; honoured once it is gone
    clr_a = 1'b1;
    step(2);
    check("clr_ignored_f", int'(f_a), 1);
    clr_a = 1'b0;
    x_a = 7'b1111111;
    step(1);
    clr_a = 1'b1;
    step(1);
    check("clr_taken_f", int'(f_a), 0);
    clr_a = 1'b0;

    // A single failure is below threshold
    x_a = 7'b1111110;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("single_pending", int'(pend_a), 0);
    end
    check("single_fail_cnt", int'(fc_a), 1);
    check("single_f", int'(f_a), 0);

    // One-cycle dropout restarts persistence
    x_a = 7'b1111111;
    step(2);
    x_a = 7'b1111100;
    step(3);
    x_a = 7'b1111111;
    step(1);
    x_a = 7'b1111100;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("dropout_f_low", int'(f_a), 0);
    end
    step(1);
    check("dropout_f_high", int'(f_a), 1);
    check("dropout_events", int'(ev_a), 2);

    // Asynchronous reset in the alarm state takes effect immediately
    #2 Resetn = 1'b0;
    #1;
    check("async_rst_f", int'(f_a), 0);
    check("async_rst_events", int'(ev_a), 0);
    check("async_rst_fail_cnt", int'(fc_a), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    // Fault still present on X: first evaluation uses freshly sampled X
    step(1);
    check("post_rst_fail_cnt", int'(fc_a), 2);
    x_a = 7'b1111111;
    step(2);

`ifdef SENSOR_MASK_EN
    // Masked failed sensors are treated as healthy
    mask_a = 7'b0000011;
    x_a = 7'b1111100;
    step(6);
    check("mask_fail_cnt", int'(fc_a), 0);
    check("mask_f", int'(f_a), 0);
    mask_a = 7'b0000000;
    x_a = 7'b1111111;
    step(2);
`endif

    // Mixed vectors with clr, each held three cycles; model checks them
    foreach (vec_tab[k]) begin
      clr_a = vec_tab[k][7];
      x_a   = vec_tab[k][6:0];
      step(3);
    end
    clr_a = 1'b0;
    x_a = 7'b1111111;
    step(2);

    // DUT B: PERSIST=1 raises the alarm two cycles after X is applied
    check("b_events_start", int'(ev_b), 0);
    x_b = 16'hFFF8;
    step(1);
    check("b_fail_cnt", int'(fc_b), 3);
    check("b_f_c1", int'(f_b), 0);
    step(1);
    check("b_f_c2", int'(f_b), 1);
    check("b_events_1", int'(ev_b), 1);
    for (int r = 0; r < 300; r++) begin
      x_b   = 16'hFFFF;
      clr_b = 1'b1;
      step(2);
      if (r == 0) check("b_cleared_f", int'(f_b), 0);
      clr_b = 1'b0;
      x_b   = 16'hFFF8;
      step(2);
      if (r == 0) check("b_events_2", int'(ev_b), 2);
      if (r == 99) check("b_events_101", int'(ev_b), 101);
    end
    check("b_events_sat", int'(ev_b), 255);
    check("b_f_end", int'(f_b), 1);
    check("b_pending_end", int'(pend_b), 0);

    model_on = 1'b0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
